// File: rtl/sipo_pkg.sv
// Shared types and defaults for the serial-in / parallel-out beat packer.
package sipo_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FILL  = 2'd1,
    ST_PEND  = 2'd2
  } sipo_state_e;

  localparam int DEF_DATA_IN_W  = 2;
  localparam int DEF_DATA_OUT_W = 16;
  localparam bit DEF_MSB_FIRST  = 1'b0;

  // Width needed to count 0..depth inclusive.
  function automatic int len_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sipo_packer.sv
// Packs DATA_IN_W-bit beats into DATA_OUT_W-bit words with flush support and
// one-word skid (assembly buffer holds a closed word while the output is blocked).
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_EMPTY | cnt == 0, no beats assembled
// ST_FILL  | 0 < cnt < DEPTH, partial word assembling
// ST_PEND  | closed word held in assembly buffer, o_ready low
module sipo_packer
  import sipo_pkg::*;
#(
  parameter int DATA_IN_W  = DEF_DATA_IN_W,
  parameter int DATA_OUT_W = DEF_DATA_OUT_W,
  parameter bit MSB_FIRST  = DEF_MSB_FIRST,
  localparam int DEPTH     = DATA_OUT_W / DATA_IN_W,
  localparam int LEN_W     = len_w(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_IN_W-1:0]  i_data,
  input  logic                  i_flush,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_OUT_W-1:0] o_data,
  output logic [LEN_W-1:0]      o_len
);

  if (((DATA_OUT_W % DATA_IN_W) != 0) || (DEPTH < 2)) begin : g_bad_params
    $error("sipo_packer: DATA_OUT_W must be a multiple of DATA_IN_W with DEPTH >= 2");
  end

  sipo_state_e           state_q, state_d;
  logic [LEN_W-1:0]      cnt_q, cnt_d;
  logic [LEN_W-1:0]      pend_len_q, pend_len_d;
  logic [DATA_OUT_W-1:0] asm_q, asm_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_OUT_W-1:0] out_data_q, out_data_d;
  logic [LEN_W-1:0]      out_len_q, out_len_d;

  logic                  ready;
  logic                  accept;
  logic [LEN_W-1:0]      beats;
  logic [DATA_OUT_W-1:0] asm_word;
  logic                  close;
  logic                  out_free;
  logic                  consumed;

  always_comb begin
    ready    = (state_q != ST_PEND) & ~i_rst;
    accept   = i_valid & ready;
    beats    = cnt_q + LEN_W'(accept);
    out_free = ~out_valid_q | i_ready;
    consumed = out_valid_q & i_ready;

    asm_word = asm_q;
    for (int k = 0; k < DEPTH; k++) begin
      if (accept && (cnt_q == LEN_W'(k))) begin
        asm_word[(MSB_FIRST ? (DEPTH - 1 - k) : k) * DATA_IN_W +: DATA_IN_W] = i_data;
      end
    end

    // Flush only closes a word that actually holds at least one beat.
    close = (accept & (cnt_q == LEN_W'(DEPTH - 1)))
          | (i_flush & ready & (beats != '0));
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_len_d  = pend_len_q;
    asm_d       = asm_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_len_d   = out_len_q;

    if (consumed) begin
      out_valid_d = 1'b0;
      out_data_d  = '0;
      out_len_d   = '0;
    end

    unique case (state_q)
      ST_PEND: begin
        if (consumed) begin
          out_valid_d = 1'b1;
          out_data_d  = asm_q;
          out_len_d   = pend_len_q;
          asm_d       = '0;
          pend_len_d  = '0;
          cnt_d       = '0;
          state_d     = ST_EMPTY;
        end
      end
      default: begin
        if (close && out_free) begin
          out_valid_d = 1'b1;
          out_data_d  = asm_word;
          out_len_d   = beats;
          asm_d       = '0;
          cnt_d       = '0;
          state_d     = ST_EMPTY;
        end else if (close) begin
          asm_d      = asm_word;
          pend_len_d = beats;
          cnt_d      = LEN_W'(DEPTH);
          state_d    = ST_PEND;
        end else begin
          asm_d   = asm_word;
          cnt_d   = beats;
          state_d = (beats == '0) ? ST_EMPTY : ST_FILL;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_EMPTY;
      cnt_q       <= '0;
      pend_len_q  <= '0;
      asm_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_len_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_len_q  <= pend_len_d;
      asm_q       <= asm_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_len_q   <= out_len_d;
    end
  end

  assign o_ready = ready;
  assign o_valid = out_valid_q;
  assign o_data  = out_data_q;
  assign o_len   = out_len_q;

endmodule

// File: tb/tb_sipo_packer.sv
// Directed bench: LSB-first and MSB-first packers (2-bit beats, 8-bit words) share stimulus.
module tb_sipo_packer;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid;
  logic [1:0] din;
  logic       flush;
  logic       rdy_dn;

  logic       ready_l, valid_l, ready_m, valid_m;
  logic [7:0] data_l, data_m;
  logic [2:0] len_l, len_m;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sipo_packer #(.DATA_IN_W(2), .DATA_OUT_W(8), .MSB_FIRST(1'b0)) u_lsb (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(ready_l), .i_data(din),
    .i_flush(flush), .o_valid(valid_l), .i_ready(rdy_dn), .o_data(data_l), .o_len(len_l)
  );

  sipo_packer #(.DATA_IN_W(2), .DATA_OUT_W(8), .MSB_FIRST(1'b1)) u_msb (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(ready_m), .i_data(din),
    .i_flush(flush), .o_valid(valid_m), .i_ready(rdy_dn), .o_data(data_m), .o_len(len_m)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] d, input logic f);
    valid = v;
    din   = d;
    flush = f;
  endtask

  task automatic chk_ready(input string tag, input int exp);
    chk({tag, ".ready_lsb"}, int'(ready_l), exp);
    chk({tag, ".ready_msb"}, int'(ready_m), exp);
  endtask

  task automatic chk_word(input string tag, input int v, input int dl, input int dm, input int len);
    chk({tag, ".valid_lsb"}, int'(valid_l), v);
    chk({tag, ".valid_msb"}, int'(valid_m), v);
    chk({tag, ".data_lsb"},  int'(data_l),  dl);
    chk({tag, ".data_msb"},  int'(data_m),  dm);
    chk({tag, ".len_lsb"},   int'(len_l),   len);
    chk({tag, ".len_msb"},   int'(len_m),   len);
  endtask

  initial begin
    logic [1:0] stall_beats [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd3, 2'd0};

    rst = 1'b1; rdy_dn = 1'b1;
    drive(1'b0, 2'd0, 1'b0);
    tick(); tick();
    chk_ready("rst", 0);
    chk_word("rst", 0, 8'h00, 8'h00, 0);
    rst = 1'b0;
    #1;
    chk_ready("rst_release", 1);

    // Full word, output free
    drive(1'b1, 2'b01, 1'b0); tick();
    drive(1'b1, 2'b10, 1'b0); tick();
    drive(1'b1, 2'b11, 1'b0); tick();
    chk_word("full_partial", 0, 8'h00, 8'h00, 0);
    drive(1'b1, 2'b00, 1'b0); tick();
    chk_word("full", 1, 8'h39, 8'h6C, 4);
    drive(1'b0, 2'b00, 1'b0); tick();
    chk_word("full_drain", 0, 8'h00, 8'h00, 0);

    // Flush on the third beat, then idle flushes produce nothing
    drive(1'b1, 2'b11, 1'b0); tick();
    drive(1'b1, 2'b11, 1'b0); tick();
    drive(1'b1, 2'b11, 1'b1); tick();
    chk_word("flush3", 1, 8'h3F, 8'hFC, 3);
    drive(1'b0, 2'b00, 1'b1); tick();
    chk_word("idle_flush1", 0, 8'h00, 8'h00, 0);
    drive(1'b0, 2'b00, 1'b1); tick();
    chk_word("idle_flush2", 0, 8'h00, 8'h00, 0);

    // Backpressure: two words queued, ninth beat stalls
    rdy_dn = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, stall_beats[i], 1'b0);
      tick();
    end
    chk_ready("stall_full", 0);
    chk_word("stall_a", 1, 8'hE4, 8'h1B, 4);
    drive(1'b1, 2'b11, 1'b0);
    tick(); tick();
    chk_ready("stall_hold", 0);
    chk_word("stall_a_hold", 1, 8'hE4, 8'h1B, 4);
    rdy_dn = 1'b1;
    tick();
    chk_word("stall_b", 1, 8'h39, 8'h6C, 4);
    chk_ready("stall_reopen", 1);
    tick();
    chk_word("stall_b_drain", 0, 8'h00, 8'h00, 0);
    drive(1'b0, 2'b00, 1'b1); tick();
    chk_word("stall_ninth", 1, 8'h03, 8'hC0, 1);
    drive(1'b0, 2'b00, 1'b0); tick();
    chk_word("stall_empty", 0, 8'h00, 8'h00, 0);

    // Streaming at one beat per cycle
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 2'(i % 4), 1'b0);
      chk_ready($sformatf("stream%0d", i), 1);
      tick();
      if ((i % 4) == 3) chk_word($sformatf("stream%0d", i), 1, 8'hE4, 8'h1B, 4);
      else              chk_word($sformatf("stream%0d", i), 0, 8'h00, 8'h00, 0);
    end

    // Reset mid-word discards the partial beats
    drive(1'b1, 2'b11, 1'b0); tick();
    drive(1'b1, 2'b10, 1'b0); tick();
    rst = 1'b1;
    drive(1'b0, 2'b00, 1'b0);
    tick();
    rst = 1'b0;
    #1;
    chk_ready("midrst", 1);
    chk_word("midrst", 0, 8'h00, 8'h00, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'b01, 1'b0);
      tick();
    end
    chk_word("midrst_partial", 0, 8'h00, 8'h00, 0);
    drive(1'b1, 2'b01, 1'b0); tick();
    chk_word("midrst_word", 1, 8'h55, 8'h55, 4);
    drive(1'b0, 2'b00, 1'b0); tick();
    chk_word("midrst_drain", 0, 8'h00, 8'h00, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/sipo_packer.md
SIPO_PACKER -- requirements
Module: sipo_packer

Interface
REQ-001 SHALL have parameter DATA_IN_W, default 2, the input beat width in bits (one Viterbi rate-1/2 symbol pair).
REQ-002 SHALL have parameter DATA_OUT_W, default 16, the packed word width in bits.
REQ-003 SHALL have parameter MSB_FIRST, default 0; 0 places the first beat in the LSBs, 1 places it in the MSBs.
REQ-004 SHALL derive DEPTH = DATA_OUT_W/DATA_IN_W and LEN_W = $clog2(DEPTH+1); elaboration SHALL fail unless DATA_OUT_W%DATA_IN_W==0 and DEPTH>=2.
REQ-005 i_clk  input  1  sole clock, rising edge.
REQ-006 i_rst  input  1  synchronous active-high reset.
REQ-007 i_valid  input  1  input beat valid.
REQ-008 o_ready  output  1  block accepts a beat this cycle.
REQ-009 i_data  input  DATA_IN_W  input beat.
REQ-010 i_flush  input  1  close the current word after this cycle, partial if needed.
REQ-011 o_valid  output  1  packed word valid.
REQ-012 i_ready  input  1  downstream accepts the word.
REQ-013 o_data  output  DATA_OUT_W  packed word.
REQ-014 o_len  output  LEN_W  number of valid beats in o_data, 1..DEPTH.

Function
REQ-015 A beat SHALL be accepted iff i_valid & o_ready; a word SHALL be consumed iff o_valid & i_ready.
REQ-016 Beat k of a word (k=0..DEPTH-1) SHALL land at bits [k*DATA_IN_W +: DATA_IN_W] if MSB_FIRST=0, else at [(DEPTH-1-k)*DATA_IN_W +: DATA_IN_W].
REQ-017 Beat counter cnt (0..DEPTH) SHALL increment per accepted beat; cnt==DEPTH SHALL mean assembly full and pending.
REQ-018 A word SHALL close when the DEPTH-th beat is accepted, or when i_flush & o_ready is high and cnt plus the beat accepted this cycle is >=1.
REQ-019 A closing word SHALL load the output register on the same edge if ~o_valid | i_ready, giving o_valid one cycle after the closing beat, and cnt SHALL return to 0.
REQ-020 Otherwise the closed word SHALL be held in the assembly buffer (cnt=DEPTH, o_ready=0) and SHALL transfer to the output register on the edge at which the current output word is consumed.
REQ-021 o_ready SHALL be 0 iff a closed word is pending in the assembly buffer; with i_ready=1 the block SHALL sustain one beat per cycle indefinitely.
REQ-022 A flushed word SHALL have unfilled beat positions zero and o_len = beats held; full words SHALL have o_len=DEPTH.
REQ-023 i_flush with cnt==0 and no accepted beat SHALL produce no word; i_flush while o_ready=0 SHALL be ignored.
REQ-024 o_data and o_len SHALL be stable while o_valid & ~i_ready, and SHALL be zero whenever o_valid=0.
REQ-025 Words SHALL leave strictly in closing order; no beat SHALL be dropped or duplicated.
REQ-026 States: EMPTY (cnt=0), FILL (0<cnt<DEPTH), PEND (closed word in assembly); EMPTY/FILL->PEND on a closing event with output blocked; PEND->EMPTY on output consumption.

Reset
REQ-027 With i_rst high at a rising edge: cnt=0, assembly and output registers=0, o_valid=0, o_data=0, o_len=0, state EMPTY.
REQ-028 o_ready SHALL be 0 while i_rst is high and 1 in the first cycle after release; reset mid-word SHALL discard all partial and pending data.

Structure
REQ-029 Package sipo_pkg SHALL hold the state enum, default parameter values and the LEN_W helper function.
REQ-030 No sub-module is required; beat placement SHALL be a local combinational block.

Verification (DATA_IN_W=2, DATA_OUT_W=8, DEPTH=4)
REQ-031 MSB_FIRST=0, i_ready=1, beats 01,10,11,00 -> o_valid one cycle after 4th beat, o_data=0x39, o_len=4.
REQ-032 MSB_FIRST=1, same beats -> o_data=0x6C, o_len=4.
REQ-033 Beats 11,11,11 with i_flush on the third -> o_data=0x3F, o_len=3 (MSB_FIRST=1: 0xFC); idle i_flush afterwards -> no word.
REQ-034 i_ready=0, 9 offered beats -> o_ready=0 after 8th accepted, 9th stalls; raise i_ready -> two words in order, then 9th accepted.
REQ-035 i_ready=1, 16 back-to-back beats -> 4 words, o_valid every 4th cycle, o_ready never 0.
REQ-036 Two beats, i_rst for one cycle, then beats 01,01,01,01 -> single word 0x55, o_len=4.
